// File: rtl/parallel_converter_n_to_1.sv
// -----------------------------------------------------------------------------
// parallel_converter_n_to_1
//
// Purpose:
//   Re-serialises an N_LANES x LEN_CODED_BLOCK coded-block bus into one block
//   per output slot, lane 0 first. This is the inverse of the 1-to-N converter
//   and sits directly downstream of it on the loopback/check path. Output slot
//   timing comes from an external valid generator (i_valid).
//
//   Two bus buffers are kept: "active" (the bus being drained) and "shadow"
//   (the next bus, parked while active drains). This lets a new bus arrive
//   while the previous one is still being emitted. There is no back-pressure:
//   a bus arriving while both buffers are occupied is dropped and flagged on
//   the sticky o_overflow output.
//
// Ports:
//   i_clock     in   1                 system clock, rising edge
//   i_reset     in   1                 asynchronous, active-low reset
//   i_enable    in   1                 global enable; low freezes all state
//   i_load      in   1                 input bus valid, one-cycle strobe
//   i_data      in   NB_DATA_BUS       input bus, lane k at
//                                      i_data[NB_DATA_BUS-1-k*LEN_CODED_BLOCK -: LEN_CODED_BLOCK]
//   i_valid     in   1                 output slot strobe
//   o_data      out  LEN_CODED_BLOCK   serialised block (registered, holds between pulses)
//   o_valid     out  1                 one-cycle pulse per emitted block
//   o_busy      out  1                 high while draining a bus (RUN)
//   o_overflow  out  1                 sticky: a bus was dropped
// -----------------------------------------------------------------------------
module parallel_converter_n_to_1 #(
  parameter int LEN_CODED_BLOCK = 66,
  parameter int N_LANES         = 20,
  parameter int NB_DATA_BUS     = N_LANES * LEN_CODED_BLOCK,
  parameter int NB_LANE_IDX     = 5
) (
  input  logic                       i_clock,
  input  logic                       i_reset,
  input  logic                       i_enable,
  input  logic                       i_load,
  input  logic [NB_DATA_BUS-1:0]     i_data,
  input  logic                       i_valid,
  output logic [LEN_CODED_BLOCK-1:0] o_data,
  output logic                       o_valid,
  output logic                       o_busy,
  output logic                       o_overflow
);

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  localparam logic [NB_LANE_IDX-1:0] LAST_LANE = NB_LANE_IDX'(N_LANES - 1);
  localparam logic [NB_LANE_IDX-1:0] LANE_ZERO = '0;
  localparam logic [NB_LANE_IDX-1:0] LANE_ONE  = NB_LANE_IDX'(1);

  // ---------------------------------------------------------------------------
  // State and datapath registers
  // ---------------------------------------------------------------------------
  state_t                      state_reg,       state_next;
  logic [NB_LANE_IDX-1:0]      lane_idx_reg,    lane_idx_next;
  logic [NB_DATA_BUS-1:0]      active_reg,      active_next;
  logic [NB_DATA_BUS-1:0]      shadow_reg,      shadow_next;
  logic                        shadow_full_reg, shadow_full_next;
  logic [LEN_CODED_BLOCK-1:0]  data_reg,        data_next;
  logic                        valid_reg,       valid_next;
  logic                        overflow_reg,    overflow_next;

  // ---------------------------------------------------------------------------
  // Lane view of the active buffer. Lane 0 occupies the most significant
  // block of the bus, so lane k is counted down from the top.
  // ---------------------------------------------------------------------------
  logic [LEN_CODED_BLOCK-1:0] active_lane [N_LANES];

  generate
    for (genvar gi = 0; gi < N_LANES; gi++) begin : g_lane
      assign active_lane[gi] = active_reg[NB_DATA_BUS-1-gi*LEN_CODED_BLOCK -: LEN_CODED_BLOCK];
    end
  endgenerate

  // Lane selector: compare against every legal lane index explicitly so that
  // index values at or beyond N_LANES simply select zero instead of indexing
  // past the end of the array.
  logic [LEN_CODED_BLOCK-1:0] lane_sel;

  always_comb begin
    lane_sel = '0;
    for (int k = 0; k < N_LANES; k++) begin
      if (lane_idx_reg == NB_LANE_IDX'(k)) begin
        lane_sel = active_lane[k];
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state / datapath logic
  // ---------------------------------------------------------------------------
  logic load_consumed;

  always_comb begin
    state_next       = state_reg;
    lane_idx_next    = lane_idx_reg;
    active_next      = active_reg;
    shadow_next      = shadow_reg;
    shadow_full_next = shadow_full_reg;
    data_next        = data_reg;
    valid_next       = 1'b0;
    overflow_next    = overflow_reg;
    load_consumed    = 1'b0;

    if (i_enable) begin
      unique case (state_reg)
        IDLE: begin
          // A slot strobe arriving together with the load has nothing to
          // emit yet; the first block goes out on the next slot.
          if (i_load) begin
            active_next   = i_data;
            lane_idx_next = LANE_ZERO;
            state_next    = RUN;
          end
        end

        RUN: begin
          if (i_valid) begin
            data_next  = lane_sel;
            valid_next = 1'b1;

            if (lane_idx_reg != LAST_LANE) begin
              lane_idx_next = lane_idx_reg + LANE_ONE;
            end else if (shadow_full_reg) begin
              // Hand over the parked bus; a load in this same cycle refills
              // the shadow immediately so no bus is lost at the boundary.
              active_next      = shadow_reg;
              lane_idx_next    = LANE_ZERO;
              shadow_full_next = i_load;
              if (i_load) begin
                shadow_next = i_data;
              end
              load_consumed = 1'b1;
            end else if (i_load) begin
              // Shadow empty: a load on the last slot goes straight into
              // the active buffer, keeping the output stream gap-free.
              active_next   = i_data;
              lane_idx_next = LANE_ZERO;
              load_consumed = 1'b1;
            end else begin
              lane_idx_next = LANE_ZERO;
              state_next    = IDLE;
            end
          end

          // Any load not taken by the last-lane handover lands in the
          // shadow, or is dropped if the shadow is already occupied.
          if (i_load && !load_consumed) begin
            if (!shadow_full_reg) begin
              shadow_next      = i_data;
              shadow_full_next = 1'b1;
            end else begin
              overflow_next = 1'b1;
            end
          end
        end

        default: begin
          state_next = IDLE;
        end
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      state_reg       <= IDLE;
      lane_idx_reg    <= '0;
      active_reg      <= '0;
      shadow_reg      <= '0;
      shadow_full_reg <= 1'b0;
      data_reg        <= '0;
      valid_reg       <= 1'b0;
      overflow_reg    <= 1'b0;
    end else begin
      state_reg       <= state_next;
      lane_idx_reg    <= lane_idx_next;
      active_reg      <= active_next;
      shadow_reg      <= shadow_next;
      shadow_full_reg <= shadow_full_next;
      data_reg        <= data_next;
      valid_reg       <= valid_next;
      overflow_reg    <= overflow_next;
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign o_data     = data_reg;
  assign o_valid    = valid_reg;
  assign o_busy     = (state_reg == RUN);
  assign o_overflow = overflow_reg;

endmodule

// File: tb/tb_parallel_converter_n_to_1.sv
// -----------------------------------------------------------------------------
// tb_parallel_converter_n_to_1
//
// Drives parallel_converter_n_to_1 with directed scenarios followed by
// randomized load/slot/enable traffic. The reference model treats the two
// bus buffers as one FIFO of pending blocks: a load is accepted when the
// blocks still pending (after this cycle's emission) span fewer than two
// buses, and each slot strobe pops one block from the front.
// -----------------------------------------------------------------------------
module tb_parallel_converter_n_to_1;

  localparam int LEN         = 66;
  localparam int N           = 20;
  localparam int NB          = N * LEN;
  localparam int NB_LANE_IDX = 5;

  logic             tb_clock;
  logic             i_reset;
  logic             i_enable;
  logic             i_load;
  logic [NB-1:0]    i_data;
  logic             i_valid;
  logic [LEN-1:0]   o_data;
  logic             o_valid;
  logic             o_busy;
  logic             o_overflow;

  parallel_converter_n_to_1 #(
    .LEN_CODED_BLOCK (LEN),
    .N_LANES         (N),
    .NB_DATA_BUS     (NB),
    .NB_LANE_IDX     (NB_LANE_IDX)
  ) dut (
    .i_clock    (tb_clock),
    .i_reset    (i_reset),
    .i_enable   (i_enable),
    .i_load     (i_load),
    .i_data     (i_data),
    .i_valid    (i_valid),
    .o_data     (o_data),
    .o_valid    (o_valid),
    .o_busy     (o_busy),
    .o_overflow (o_overflow)
  );

  initial tb_clock = 1'b0;
  always #5 tb_clock = ~tb_clock;

  int tests_run    = 0;
  int tests_failed = 0;

  // Reference model state
  logic [LEN-1:0] pend [$];
  logic [LEN-1:0] exp_data;
  logic           exp_valid;
  logic           exp_busy;
  logic           exp_ovf;

  logic [NB-1:0] bus_a, bus_b, bus_c, bus_d;

  task automatic check(input string tag, input logic [LEN-1:0] got, input logic [LEN-1:0] want);
    tests_run++;
    if (got !== want) begin
      tests_failed++;
      $display("[TB] FAIL %s: got %h, expected %h (t=%0t)", tag, got, want, $time);
    end
  endtask

  function automatic logic [NB-1:0] make_bus(input logic [1:0] prefix, input logic [63:0] base);
    logic [NB-1:0] b;
    b = '0;
    for (int k = 0; k < N; k++) begin
      b[NB-1-k*LEN -: LEN] = {prefix, base + 64'(k)};
    end
    return b;
  endfunction

  function automatic logic [NB-1:0] rand_bus();
    logic [NB-1:0]  b;
    logic [LEN-1:0] l;
    b = '0;
    for (int k = 0; k < N; k++) begin
      l[65:64] = 2'($urandom);
      l[63:32] = $urandom;
      l[31:0]  = $urandom;
      b[NB-1-k*LEN -: LEN] = l;
    end
    return b;
  endfunction

  task automatic check_outputs(input string pfx);
    check({pfx, "o_valid"},    LEN'(o_valid),    LEN'(exp_valid));
    check({pfx, "o_data"},     o_data,           exp_data);
    check({pfx, "o_busy"},     LEN'(o_busy),     LEN'(exp_busy));
    check({pfx, "o_overflow"}, LEN'(o_overflow), LEN'(exp_ovf));
  endtask

  // One clock cycle: called at a falling edge, drives inputs, advances the
  // model across the next rising edge, then checks at the following falling
  // edge.
  task automatic cycle(input logic ld, input logic vd, input logic en, input logic [NB-1:0] bus);
    int held;
    i_load   = ld;
    i_valid  = vd;
    i_enable = en;
    i_data   = bus;

    exp_valid = 1'b0;
    if (en) begin
      if (vd && pend.size() > 0) begin
        exp_data  = pend.pop_front();
        exp_valid = 1'b1;
      end
      if (ld) begin
        held = (pend.size() + N - 1) / N;
        if (held < 2) begin
          for (int k = 0; k < N; k++) pend.push_back(bus[NB-1-k*LEN -: LEN]);
          $display("[TB] load accepted at t=%0t, lane0=%h, pending=%0d", $time, bus[NB-1 -: LEN], pend.size());
        end else begin
          exp_ovf = 1'b1;
          $display("[TB] load dropped at t=%0t, lane0=%h", $time, bus[NB-1 -: LEN]);
        end
      end
      exp_busy = (pend.size() > 0);
    end

    @(negedge tb_clock);
    check_outputs("");
  endtask

  // Asynchronous reset pulse asserted between clock edges; outputs must clear
  // immediately, without waiting for a rising edge.
  task automatic async_reset();
    #2 i_reset = 1'b0;
    pend.delete();
    exp_valid = 1'b0;
    exp_data  = '0;
    exp_busy  = 1'b0;
    exp_ovf   = 1'b0;
    #1 check_outputs("rst_");
    @(negedge tb_clock);
    i_reset  = 1'b1;
    i_load   = 1'b0;
    i_valid  = 1'b0;
    i_enable = 1'b1;
    check_outputs("rst_rel_");
  endtask

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int lp, vp;
    i_reset  = 1'b0;
    i_enable = 1'b1;
    i_load   = 1'b0;
    i_valid  = 1'b0;
    i_data   = '0;
    pend.delete();
    exp_valid = 1'b0;
    exp_data  = '0;
    exp_busy  = 1'b0;
    exp_ovf   = 1'b0;

    bus_a = make_bus(2'b01, 64'h0);
    bus_b = make_bus(2'b10, 64'h100);
    bus_c = make_bus(2'b11, 64'h200);
    bus_d = make_bus(2'b01, 64'h300);

    #1 check_outputs("por_");
    @(negedge tb_clock);
    @(negedge tb_clock);
    i_reset = 1'b1;
    check_outputs("por_rel_");

    // 1: single bus, slot every cycle
    $display("[TB] scenario 1: single bus");
    cycle(1'b1, 1'b1, 1'b1, bus_a);
    for (int i = 0; i < 24; i++) cycle(1'b0, 1'b1, 1'b1, '0);

    // 2: second bus loaded at slot 5
    $display("[TB] scenario 2: back-to-back via shadow");
    async_reset();
    cycle(1'b1, 1'b1, 1'b1, bus_a);
    for (int i = 0; i < 45; i++) cycle(i == 5, 1'b1, 1'b1, bus_b);

    // 3: second bus on the last-lane slot, shadow empty
    $display("[TB] scenario 3: load on last lane");
    async_reset();
    cycle(1'b1, 1'b1, 1'b1, bus_a);
    for (int i = 0; i < 45; i++) cycle(i == 19, 1'b1, 1'b1, bus_b);

    // 4: three loads within one drain
    $display("[TB] scenario 4: overflow");
    async_reset();
    cycle(1'b1, 1'b1, 1'b1, bus_a);
    for (int i = 0; i < 45; i++) begin
      if (i == 3)      cycle(1'b1, 1'b1, 1'b1, bus_b);
      else if (i == 8) cycle(1'b1, 1'b1, 1'b1, bus_c);
      else             cycle(1'b0, 1'b1, 1'b1, '0);
    end

    // 5: enable low for 7 cycles at lane 9 (stray load/slot strobes ignored)
    $display("[TB] scenario 5: enable freeze");
    async_reset();
    cycle(1'b1, 1'b1, 1'b1, bus_a);
    for (int i = 0; i < 9; i++)  cycle(1'b0, 1'b1, 1'b1, '0);
    for (int i = 0; i < 7; i++)  cycle(i == 3, 1'b1, 1'b0, bus_d);
    for (int i = 0; i < 15; i++) cycle(1'b0, 1'b1, 1'b1, '0);

    // 6: async reset mid-drain with shadow full, then no stale output
    $display("[TB] scenario 6: async reset mid-drain");
    async_reset();
    cycle(1'b1, 1'b1, 1'b1, bus_a);
    for (int i = 0; i < 12; i++) cycle(i == 2, 1'b1, 1'b1, bus_b);
    async_reset();
    for (int i = 0; i < 25; i++) cycle(1'b0, 1'b1, 1'b1, '0);
    cycle(1'b1, 1'b1, 1'b1, bus_c);
    for (int i = 0; i < 22; i++) cycle(1'b0, 1'b1, 1'b1, '0);

    // Randomized traffic, with load pressure rising per segment
    for (int seg = 0; seg < 6; seg++) begin
      $display("[TB] random segment %0d", seg);
      async_reset();
      lp = 60 - seg * 9;
      vp = 2 + seg % 3;
      for (int i = 0; i < 600; i++) begin
        cycle(($urandom_range(lp - 1, 0) == 0),
              ($urandom_range(vp, 0) != 0),
              ($urandom_range(15, 0) != 0),
              rand_bus());
      end
      if ($urandom_range(1, 0) == 1) async_reset();
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
